uart_tx_queue: RTL and testbench

Byte queue placed directly upstream of the `Uart8` transmitter. It accepts bytes from a producer over a valid/ready handshake and buffers them in a FIFO. It then feeds them one at a time into `Uart8`'s `txStart`/`txIn`/`txBusy` interface, so software or a packet engine can burst bytes without pacing itself to the baud rate.

---
 rtl/uart_pkg.sv | 13 +
 rtl/byte_fifo.sv | 57 +++++
 rtl/uart_tx_queue.sv | 120 ++++++++++++
 tb/tb_uart_tx_queue.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: data width and the queue-to-Uart8
// handshake state encoding.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2
    } tx_queue_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO: circular memory, wrapping pointers, occupancy count
// and flags. Pushes while full and pops while empty are ignored.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [UART_DATA_W-1:0] wdata,
    output logic [UART_DATA_W-1:0] rdata,
    output logic [AW:0]            count,
    output logic                   empty,
    output logic                   full
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [AW:0]            count_q;
    logic                   do_push;
    logic                   do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers are exactly AW bits, so wrap modulo DEPTH comes for free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue in front of Uart8: buffers producer bytes and hands them to the
// transmitter one frame at a time through the txStart/txBusy handshake.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   inValid,
    input  logic [UART_DATA_W-1:0] inData,
    output logic                   inReady,
    input  logic                   clrOvf,
    output logic                   txEn,
    output logic                   txStart,
    output logic [UART_DATA_W-1:0] txIn,
    input  logic                   txBusy,
    input  logic                   txDone,
    output logic [AW:0]            count,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    output logic                   idle
);

    tx_queue_state_t        state_q;
    logic                   txStart_q;
    logic                   txEn_q;
    logic [UART_DATA_W-1:0] txIn_q;
    logic                   overflow_q;
    logic                   overflow_d;
    logic                   push;
    logic                   pop;
    logic [UART_DATA_W-1:0] fifo_rdata;
    logic                   unused_txdone;

    assign unused_txdone = txDone;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (inData),
        .rdata (fifo_rdata),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    // inReady is taken from the pre-pop fullness, so a push racing a pop on a
    // full queue is rejected.
    assign inReady = !full;
    assign push    = inValid && inReady;
    assign pop     = (state_q == IDLE) && en && !empty;

    always_comb begin
        overflow_d = overflow_q;
        if (inValid && full) begin
            overflow_d = 1'b1;
        end else if (clrOvf) begin
            overflow_d = 1'b0;
        end
    end

    // txStart is held until Uart8 answers with txBusy (it only samples on baud
    // ticks), then dropped so the same byte is not sent twice.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            txStart_q  <= 1'b0;
            txEn_q     <= 1'b0;
            txIn_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        txIn_q    <= fifo_rdata;
                        txStart_q <= 1'b1;
                        txEn_q    <= 1'b1;
                        state_q   <= START;
                    end else begin
                        txEn_q <= en;
                    end
                end
                START: begin
                    txEn_q <= 1'b1;
                    if (txBusy) begin
                        txStart_q <= 1'b0;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    if (!txBusy) begin
                        txEn_q  <= en;
                        state_q <= IDLE;
                    end else begin
                        txEn_q <= 1'b1;
                    end
                end
                default: begin
                    txStart_q <= 1'b0;
                    txEn_q    <= en;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign txStart  = txStart_q;
    assign txEn     = txEn_q;
    assign txIn     = txIn_q;
    assign overflow = overflow_q;
    assign idle     = empty && (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomised bench for uart_tx_queue against a queue-based frame model, with a
// simple behavioural stand-in for the Uart8 txStart/txBusy handshake.
module tb_uart_tx_queue;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en, inValid, clrOvf, txBusy, txDone;
    logic [7:0] inData, txIn;
    logic       inReady, txEn, txStart, empty, full, overflow, idle;
    logic [4:0] count;

    int n_cmp = 0;
    int n_err = 0;
    int rx_n = 0;
    int rsp_phase = 0;
    logic [7:0] last_rx = 8'h00;

    always #5 clk = ~clk;

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .en(en), .inValid(inValid), .inData(inData),
        .inReady(inReady), .clrOvf(clrOvf), .txEn(txEn), .txStart(txStart),
        .txIn(txIn), .txBusy(txBusy), .txDone(txDone), .count(count),
        .empty(empty), .full(full), .overflow(overflow), .idle(idle)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: a queue of stored bytes plus "frame in flight" and
    // "transmitter has acknowledged" flags.
    logic [7:0] m_q[$];
    logic [7:0] exp_tx[$];
    bit         m_active = 0, m_acked = 0, m_ovf = 0, m_txen = 0;
    logic [7:0] m_txin = 8'h00;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_q.delete(); exp_tx.delete();
                m_active = 0; m_acked = 0; m_ovf = 0; m_txen = 0; m_txin = 8'h00;
            end else begin
                bit do_push, do_pop, ovf_set;
                do_push = inValid && (m_q.size() < DEPTH);
                ovf_set = inValid && (m_q.size() == DEPTH);
                do_pop  = !m_active && en && (m_q.size() != 0);
                if (ovf_set) m_ovf = 1; else if (clrOvf) m_ovf = 0;
                if (m_active) begin
                    if (!m_acked) begin
                        if (txBusy) m_acked = 1;
                    end else if (!txBusy) begin
                        m_active = 0;
                    end
                end
                if (do_pop) begin
                    m_txin = m_q.pop_front();
                    exp_tx.push_back(m_txin);
                    m_active = 1;
                    m_acked = 0;
                end
                if (do_push) m_q.push_back(inData);
                m_txen = en || m_active;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("count",    32'(count),    32'(m_q.size()));
                chk("empty",    32'(empty),    32'(m_q.size() == 0));
                chk("full",     32'(full),     32'(m_q.size() == DEPTH));
                chk("inReady",  32'(inReady),  32'(m_q.size() != DEPTH));
                chk("overflow", 32'(overflow), 32'(m_ovf));
                chk("idle",     32'(idle),     32'(m_q.size() == 0 && !m_active));
                chk("txStart",  32'(txStart),  32'(m_active && !m_acked));
                chk("txEn",     32'(txEn),     32'(m_txen));
                chk("txIn",     32'(txIn),     32'(m_txin));
            end
        end
    end

    // Uart8 stand-in: waits 0..3 cycles for a "baud tick", captures txIn when
    // raising txBusy, stays busy 2..6 cycles.
    initial begin
        int wait_cnt, busy_cnt;
        txBusy = 1'b0; txDone = 1'b0; wait_cnt = 0; busy_cnt = 0;
        forever begin
            @(posedge clk); #1;
            txDone = 1'b0;
            if (reset) begin
                txBusy = 1'b0; rsp_phase = 0;
            end else begin
                case (rsp_phase)
                    0: if (txStart) begin
                        wait_cnt = $urandom_range(0, 3); rsp_phase = 1;
                    end
                    1: if (wait_cnt == 0) begin
                        txBusy = 1'b1; rx_n++; last_rx = txIn;
                        chk("rx_frame_expected", 32'(exp_tx.size() != 0), 1);
                        if (exp_tx.size() != 0) chk("rx_byte", 32'(txIn), 32'(exp_tx.pop_front()));
                        busy_cnt = $urandom_range(1, 5); rsp_phase = 2;
                    end else wait_cnt--;
                    default: if (busy_cnt == 0) begin
                        txBusy = 1'b0; txDone = 1'b1; rsp_phase = 0;
                    end else busy_cnt--;
                endcase
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_byte(input logic [7:0] b);
        inValid = 1'b1; inData = b; step(); inValid = 1'b0;
    endtask

    task automatic wait_drained(input int budget);
        int k = 0;
        while (!(idle && !txBusy && rsp_phase == 0) && k < budget) begin step(); k++; end
        chk("drain_in_time", 32'(k < budget), 1);
    endtask

    initial begin
        int k, base;
        en = 1'b0; inValid = 1'b0; inData = 8'h00; clrOvf = 1'b0;
        step(3);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_inReady", 32'(inReady), 1);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_idle", 32'(idle), 1);
        chk("rst_txStart", 32'(txStart), 0);
        chk("rst_txEn", 32'(txEn), 0);
        chk("rst_txIn", 32'(txIn), 0);
        reset = 1'b0; step();

        // single byte latency
        en = 1'b1;
        push_byte(8'h8A);
        chk("lat_count_N", 32'(count), 1);
        chk("lat_txStart_N", 32'(txStart), 0);
        step();
        chk("lat_txStart_N1", 32'(txStart), 1);
        chk("lat_txIn_N1", 32'(txIn), 32'h8A);
        chk("lat_count_N1", 32'(count), 0);
        wait_drained(100);
        chk("t1_idle", 32'(idle), 1);
        chk("t1_rx_n", 32'(rx_n), 1);
        chk("t1_rx_byte", 32'(last_rx), 32'h8A);

        // queued with en low, then released
        en = 1'b0;
        push_byte(8'h8A); push_byte(8'h7A); push_byte(8'h55);
        chk("t2_count", 32'(count), 3);
        chk("t2_txEn", 32'(txEn), 0);
        en = 1'b1;
        wait_drained(300);
        chk("t2_rx_n", 32'(rx_n), 4);
        chk("t2_last", 32'(last_rx), 32'h55);

        // fill, overflow, clear, set-wins
        en = 1'b0;
        for (int i = 0; i < 17; i++) push_byte(8'(8'hA0 + i));
        chk("t3_count", 32'(count), 16);
        chk("t3_full", 32'(full), 1);
        chk("t3_inReady", 32'(inReady), 0);
        chk("t3_ovf", 32'(overflow), 1);
        clrOvf = 1'b1; step(); clrOvf = 1'b0;
        chk("t3_ovf_clr", 32'(overflow), 0);
        inValid = 1'b1; clrOvf = 1'b1; step(); inValid = 1'b0; clrOvf = 1'b0;
        chk("t3_ovf_setwins", 32'(overflow), 1);
        clrOvf = 1'b1; step(); clrOvf = 1'b0;
        chk("t3_ovf_clr2", 32'(overflow), 0);
        en = 1'b1;
        wait_drained(1000);
        chk("t3_rx_n", 32'(rx_n), 20);
        chk("t3_last", 32'(last_rx), 32'hAF);

        // drop en while second of three is in START
        en = 1'b0;
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        en = 1'b1;
        k = 0;
        while (!(txStart && count == 1) && k < 100) begin step(); k++; end
        chk("t4_reach_start2", 32'(k < 100), 1);
        en = 1'b0;
        k = 0;
        while (txEn && k < 100) begin step(); k++; end
        chk("t4_txEn_low", 32'(txEn), 0);
        chk("t4_count", 32'(count), 1);
        chk("t4_last", 32'(last_rx), 32'h22);
        chk("t4_rx_n", 32'(rx_n), 22);
        en = 1'b1;
        wait_drained(200);
        chk("t4_rx_n_final", 32'(rx_n), 23);

        // reset while in SEND with four bytes queued
        en = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i));
        en = 1'b1;
        k = 0;
        while (!(txBusy && !txStart && count == 4) && k < 100) begin step(); k++; end
        chk("t5_reach_send", 32'(k < 100), 1);
        #2 reset = 1'b1;
        #1;
        chk("t5_count", 32'(count), 0);
        chk("t5_txStart", 32'(txStart), 0);
        chk("t5_txEn", 32'(txEn), 0);
        chk("t5_empty", 32'(empty), 1);
        step(2);
        reset = 1'b0;
        base = rx_n;
        step(40);
        chk("t5_no_rx", 32'(rx_n), 32'(base));
        chk("t5_idle", 32'(idle), 1);

        // 40 bytes interleaved with drain; pointers wrap twice
        base = rx_n;
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            k = 0;
            while (!inReady && k < 200) begin step(); k++; end
            push_byte(8'(i));
            step($urandom_range(0, 3));
        end
        wait_drained(2000);
        chk("t6_rx_n", 32'(rx_n - base), 40);
        chk("t6_last", 32'(last_rx), 39);

        // free-running random traffic
        for (int c = 0; c < 2000; c++) begin
            en      = ($urandom_range(0, 9) != 0);
            inValid = ($urandom_range(0, 2) == 0);
            inData  = 8'($urandom);
            clrOvf  = ($urandom_range(0, 15) == 0);
            step();
        end
        inValid = 1'b0; clrOvf = 1'b0; en = 1'b1;
        wait_drained(3000);
        chk("t7_drained_empty", 32'(empty), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, n_err %0d", n_err);
        $fatal(1);
    end
endmodule
